src_control_sequencer: RTL

Hardwired control-step sequencer for the Phase 1 datapath. It generates the per-cycle control signals the datapath consumes: one-hot register in/out enables, bus-source selects, memory strobes and ALU_Control. It runs instruction fetch (T0–T2), then the register-register ALU steps decoded from IR. It sits directly upstream of the datapath, whose IR output feeds `ir` and whose control inputs are driven by this block.

---
 rtl/src_control_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/src_control_sequencer.sv
// src_control_sequencer: hardwired control-step sequencer (fetch T0-T2, ALU steps T3-T6)
module src_control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  ALU_Control,
    output logic        done,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state_q;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [4:0] alu_sel;
    logic       is_alu, is_md, is_halt, is_ill;

    assign op      = ir[31:27];
    assign ra      = ir[26:23];
    assign rb      = ir[22:19];
    assign rc      = ir[18:15];
    assign is_halt = (op == 5'b11111);
    assign is_ill  = !(is_alu || is_md || is_halt);

    // Opcode to ALU operation; is_md marks the two-result ops that need T6
    always_comb begin
        alu_sel = 5'b00000;
        is_alu  = 1'b0;
        is_md   = 1'b0;
        case (op)
            5'b00001: begin alu_sel = 5'b00000; is_alu = 1'b1; end
            5'b00010: begin alu_sel = 5'b00001; is_alu = 1'b1; end
            5'b00011: begin alu_sel = 5'b00010; is_alu = 1'b1; end
            5'b00100: begin alu_sel = 5'b00011; is_alu = 1'b1; end
            5'b00101: begin alu_sel = 5'b00100; is_alu = 1'b1; end
            5'b00110: begin alu_sel = 5'b00101; is_alu = 1'b1; end
            5'b01111: begin alu_sel = 5'b01000; is_md  = 1'b1; end
            5'b10000: begin alu_sel = 5'b01001; is_md  = 1'b1; end
            default:  ;
        endcase
    end

    // Step sequencing; clear abandons any instruction in flight without waiting for an edge
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_q <= run ? S_T0 : S_IDLE;
                S_T0:    state_q <= S_T1;
                S_T1:    state_q <= S_T2;
                S_T2:    state_q <= S_T3;
                S_T3:    state_q <= is_halt ? S_HALT : is_ill ? (run ? S_T0 : S_IDLE) : S_T4;
                S_T4:    state_q <= S_T5;
                S_T5:    state_q <= is_md ? S_T6 : (run ? S_T0 : S_IDLE);
                S_T6:    state_q <= run ? S_T0 : S_IDLE;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Per-step strobe decode from the registered step and IR fields
    always_comb begin
        Rin         = 16'h0000;
        Rout        = 16'h0000;
        PCout       = 1'b0;
        PCin        = 1'b0;
        IncPC       = 1'b0;
        MARin       = 1'b0;
        Read        = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        HIin        = 1'b0;
        LOin        = 1'b0;
        ALU_Control = 5'b00000;
        done        = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_ill) begin
                    illegal = 1'b1;
                end else if (!is_halt) begin
                    Rout = 16'd1 << rb;
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                Rout        = 16'd1 << rc;
                ALU_Control = alu_sel;
                Zin         = 1'b1;
            end
            S_T5: begin
                Zlowout = 1'b1;
                LOin    = is_md;
                Rin     = is_md ? 16'h0000 : 16'd1 << ra;
                done    = !is_md;
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
